// File: rtl/dmem_responder_if.sv
// Request/response bundle between a data-memory requester and the responder.
// The requester holds req_* high until it sees ack, then drops them; ack falls on the following edge.
interface dmem_responder_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24
);
    logic              req_read;
    logic              req_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (
        output req_read, req_write, addr, data_in,
        input  data_out, ack, err, busy
    );

    modport slave (
        input  req_read, req_write, addr, data_in,
        output data_out, ack, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: single-outstanding data-memory responder with a DEPTH x DATA_W array and programmable wait states.
// Latency: request captured at edge k, ack (with err qualifier) rises at edge k+1+WAIT_CYCLES.
// Backpressure: four-phase; ack holds while any request is high, new requests accepted only from IDLE.
module dmem_responder #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 24,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_responder_if.slave bus
);
    localparam int                LP_IW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]        LP_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_op_rd;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;
    logic [DATA_W-1:0]   r_data_out;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req;
    logic                w_capture;
    logic                w_reject;
    logic                w_ack_nxt;
    logic                w_err_nxt;
    logic                w_mem_we;
    logic                w_rd_load;
    logic [LP_IW-1:0]    w_idx;

    assign w_req    = bus.req_read | bus.req_write;
    // Range check on the full captured address before it is truncated to an index.
    assign w_reject = ({1'b0, r_addr} >= LP_DEPTH) | (r_op_rd & r_op_wr);
    assign w_idx    = r_addr[LP_IW-1:0];

    // WAIT is always entered with the counter at WAIT_CYCLES, which gives k+1+WAIT_CYCLES even for zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_mem_we    = 1'b0;
        w_rd_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = w_reject;
                    w_mem_we    = r_op_wr & ~w_reject;
                    w_rd_load   = r_op_rd & ~w_reject;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op_rd    <= 1'b0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_capture) begin
                r_op_rd <= bus.req_read;
                r_op_wr <= bus.req_write;
                r_addr  <= bus.addr;
                r_data  <= bus.data_in;
            end
            if (w_rd_load) begin
                r_data_out <= r_mem[w_idx];
            end
        end
    end

    // Storage survives reset; the write strobe is already dead while the state is held in IDLE.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_data;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;
    assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized transactions on two responders (2 and 0 wait states) against an array model.
module tb_dmem_responder;
    logic clk;
    logic rst2_n;
    logic rst0_n;

    int checks;
    int errors;

    logic [23:0] mdl_mem  [2][256];
    logic [23:0] mdl_last [2];
    int          kq0 [$];
    int          kq1 [$];

    dmem_responder_if #(.ADDR_W(24), .DATA_W(24)) bif2 ();
    dmem_responder_if #(.ADDR_W(24), .DATA_W(24)) bif0 ();

    dmem_responder #(.DATA_W(24), .ADDR_W(24), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk     (clk),
        .reset_n (rst2_n),
        .bus     (bif2)
    );

    dmem_responder #(.DATA_W(24), .ADDR_W(24), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk     (clk),
        .reset_n (rst0_n),
        .bus     (bif0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? bif2.ack : bif0.ack;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bif2.err : bif0.err;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bif2.busy : bif0.busy;
    endfunction

    function automatic logic [23:0] get_dout(input int sel);
        return (sel == 0) ? bif2.data_out : bif0.data_out;
    endfunction

    task automatic drive(input int sel, input bit rd, input bit wr, input logic [23:0] a, input logic [23:0] d);
        if (sel == 0) begin
            bif2.req_read = rd; bif2.req_write = wr; bif2.addr = a; bif2.data_in = d;
        end else begin
            bif0.req_read = rd; bif0.req_write = wr; bif0.addr = a; bif0.data_in = d;
        end
    endtask

    // Called at a negedge; returns at a negedge with the requester idle again.
    task automatic txn(input int sel, input bit rd, input bit wr, input logic [23:0] a,
                       input logic [23:0] d, input int hold, input string tag);
        int          n;
        int          lat_exp;
        logic        err_exp;
        logic [23:0] dout_exp;
        logic [7:0]  idx;
        idx      = a[7:0];
        err_exp  = (a >= 24'd256) || (rd && wr);
        dout_exp = (rd && !err_exp) ? mdl_mem[sel][idx] : mdl_last[sel];
        lat_exp  = (sel == 0) ? 4 : 2;
        drive(sel, rd, wr, a, d);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                chk({tag, ".busy_on"}, 32'(get_busy(sel)), 32'd1);
                drive(sel, rd, wr, ~a, ~d);
            end
            if (get_ack(sel)) break;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat_exp));
        chk({tag, ".err"}, 32'(get_err(sel)), 32'(err_exp));
        chk({tag, ".dout"}, 32'(get_dout(sel)), 32'(dout_exp));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".ack_hold"}, 32'(get_ack(sel)), 32'd1);
            chk({tag, ".err_hold"}, 32'(get_err(sel)), 32'(err_exp));
        end
        drive(sel, 1'b0, 1'b0, a, d);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ack_rel"}, 32'(get_ack(sel)), 32'd0);
        chk({tag, ".err_rel"}, 32'(get_err(sel)), 32'd0);
        chk({tag, ".busy_rel"}, 32'(get_busy(sel)), 32'd0);
        if (wr && !err_exp) begin
            mdl_mem[sel][idx] = d;
            if (sel == 0) kq0.push_back(int'(idx));
            else          kq1.push_back(int'(idx));
        end
        mdl_last[sel] = dout_exp;
    endtask

    initial begin
        int          r;
        logic [23:0] a;
        logic [23:0] d;
        bit          rd;
        bit          wr;
        checks      = 0;
        errors      = 0;
        mdl_last[0] = 24'd0;
        mdl_last[1] = 24'd0;
        rst2_n      = 1'b0;
        rst0_n      = 1'b0;
        drive(0, 1'b0, 1'b0, 24'd0, 24'd0);
        drive(1, 1'b0, 1'b0, 24'd0, 24'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset.ack",  32'(get_ack(s)),  32'd0);
            chk("reset.err",  32'(get_err(s)),  32'd0);
            chk("reset.busy", 32'(get_busy(s)), 32'd0);
            chk("reset.dout", 32'(get_dout(s)), 32'd0);
        end
        rst2_n = 1'b1;
        rst0_n = 1'b1;

        // Two wait states
        txn(0, 1'b0, 1'b1, 24'd5, 24'hABCDEF, 1, "wr5");
        txn(0, 1'b1, 1'b0, 24'd5, 24'h000000, 2, "rd5");
        txn(0, 1'b1, 1'b0, 24'h000100, 24'h0, 0, "rd_oor");
        txn(0, 1'b0, 1'b1, 24'h000105, 24'h5A5A5A, 0, "wr_oor");
        txn(0, 1'b1, 1'b0, 24'd5, 24'h0, 0, "rd5_alias");
        txn(0, 1'b0, 1'b1, 24'd7, 24'h123456, 0, "wr7");
        txn(0, 1'b1, 1'b1, 24'd7, 24'h654321, 1, "both7");
        txn(0, 1'b1, 1'b0, 24'd7, 24'h0, 0, "rd7");
        txn(0, 1'b0, 1'b1, 24'd9, 24'h111111, 0, "wr9");

        drive(0, 1'b0, 1'b1, 24'd9, 24'h999999);
        @(posedge clk);
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("rstmid.ack",  32'(bif2.ack),  32'd0);
        chk("rstmid.busy", 32'(bif2.busy), 32'd0);
        chk("rstmid.dout", 32'(bif2.data_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 24'd0, 24'd0);
        rst2_n      = 1'b1;
        mdl_last[0] = 24'd0;
        txn(0, 1'b1, 1'b0, 24'd9, 24'h0, 0, "rd9_after_rst");

        // Zero wait states, back-to-back reads with immediate release
        txn(1, 1'b0, 1'b1, 24'd0, 24'h0F1E2D, 0, "z_wr0");
        txn(1, 1'b1, 1'b0, 24'd0, 24'h0, 0, "z_rd0a");
        txn(1, 1'b1, 1'b0, 24'd0, 24'h0, 0, "z_rd0b");
        txn(1, 1'b0, 1'b1, 24'd255, 24'hC0FFEE, 0, "z_wr255");
        txn(1, 1'b1, 1'b0, 24'd255, 24'h0, 1, "z_rd255");

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 30; i++) begin
                r  = int'($urandom_range(0, 9));
                d  = 24'($urandom);
                rd = 1'b0;
                wr = 1'b0;
                if (r < 4) begin
                    wr = 1'b1;
                    if ($urandom_range(0, 5) == 0) a = 24'(256 + $urandom_range(0, 4000));
                    else                            a = 24'($urandom_range(0, 255));
                end else if (r < 8) begin
                    rd = 1'b1;
                    if ($urandom_range(0, 6) == 0) a = 24'($urandom_range(256, 24'hFFFFFF));
                    else if (s == 0)               a = 24'(kq0[$urandom_range(0, kq0.size() - 1)]);
                    else                            a = 24'(kq1[$urandom_range(0, kq1.size() - 1)]);
                end else begin
                    rd = 1'b1;
                    wr = 1'b1;
                    a  = 24'($urandom_range(0, 300));
                end
                txn(s, rd, wr, a, d, int'($urandom_range(0, 2)), $sformatf("rnd%0d_%0d", s, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
